// File: rtl/cnn_layer_mem.sv
// cnn_layer_mem
// Multi-bank layer memory for the CNN accelerator. Bank k is addressed by
// csel = k+1. Provides a registered read port with write-first bypass,
// per-bank saturating write counters, sticky protocol-error flags and a
// valid/ready dump port that streams one whole bank in address order.
//
// Ports
//   clk, reset      rising-edge clock, asynchronous active-low reset
//   csel            bank select shared by read and write
//   crd/caddr_rd    read strobe and address; cdata_rd is registered
//   cwr/caddr_wr    write strobe, address and data (cdata_wr)
//   dump_req/sel    start a dump of bank dump_sel (sampled in IDLE only)
//   dump_valid/ready/addr/data/last  dump stream handshake and payload
//   busy            dump in progress
//   stat_sel        selects which bank's write count drives stat_wr_cnt
//   err_sel         sticky: access or dump request with an invalid bank
//   err_rd_busy     sticky: read attempted during a dump
//   err_clr         synchronous clear of both sticky flags (wins over set)
module cnn_layer_mem #(
    parameter int unsigned DATA_W   = 20,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned NUM_BANK = 5,
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned CNT_W    = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SEL_W-1:0]  csel,
    input  logic              crd,
    input  logic [ADDR_W-1:0] caddr_rd,
    output logic [DATA_W-1:0] cdata_rd,
    input  logic              cwr,
    input  logic [ADDR_W-1:0] caddr_wr,
    input  logic [DATA_W-1:0] cdata_wr,
    input  logic              dump_req,
    input  logic [SEL_W-1:0]  dump_sel,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    output logic              busy,
    input  logic [SEL_W-1:0]  stat_sel,
    output logic [CNT_W-1:0]  stat_wr_cnt,
    output logic              err_sel,
    output logic              err_rd_busy,
    input  logic              err_clr
);

    localparam int unsigned      DEPTH = 1 << ADDR_W;
    localparam logic [SEL_W-1:0] NB    = SEL_W'(NUM_BANK);
    localparam logic [SEL_W-1:0] ONE   = SEL_W'(1);

    typedef enum logic {S_IDLE, S_DUMP} state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [DATA_W-1:0] r_mem [NUM_BANK][DEPTH];
    logic [CNT_W-1:0]  r_wr_cnt [NUM_BANK];

    logic [DATA_W-1:0] r_cdata_rd;
    logic              r_dump_valid;
    logic [ADDR_W-1:0] r_dump_addr;
    logic [DATA_W-1:0] r_dump_data;
    logic              r_dump_last;
    logic [SEL_W-1:0]  r_dump_bank;
    logic              r_err_sel;
    logic              r_err_rd_busy;

    logic              w_busy;
    logic              w_csel_ok;
    logic              w_dsel_ok;
    logic              w_ssel_ok;
    logic [SEL_W-1:0]  w_bank;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic              w_dump_start;
    logic              w_xfer;
    logic              w_load;
    logic [ADDR_W-1:0] w_load_addr;
    logic              w_load_bypass;
    logic              w_set_sel;
    logic              w_set_busy;

    assign w_csel_ok    = (csel != '0) && (csel <= NB);
    assign w_dsel_ok    = (dump_sel != '0) && (dump_sel <= NB);
    assign w_ssel_ok    = (stat_sel != '0) && (stat_sel <= NB);
    assign w_bank       = csel - ONE;
    assign w_wr_ok      = cwr && w_csel_ok;
    assign w_rd_ok      = crd && w_csel_ok && !w_busy;
    assign w_dump_start = (r_state == S_IDLE) && dump_req && w_dsel_ok;
    assign w_xfer       = r_dump_valid && dump_ready;

    // The dump output register is refilled either on entry (first word) or
    // on each accepted word that is not the last. A same-cycle write to the
    // word being fetched is forwarded so not-yet-presented addresses always
    // reflect the newest data; the already-presented word never changes.
    assign w_load        = (r_state == S_DUMP) && (!r_dump_valid || (dump_ready && !r_dump_last));
    assign w_load_addr   = r_dump_valid ? r_dump_addr + ADDR_W'(1) : '0;
    assign w_load_bypass = w_wr_ok && (w_bank == r_dump_bank) && (caddr_wr == w_load_addr);

    assign w_set_sel  = ((crd || cwr) && !w_csel_ok) ||
                        ((r_state == S_IDLE) && dump_req && !w_dsel_ok);
    assign w_set_busy = crd && w_busy;

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_dump_start)          w_state_nxt = S_DUMP;
            S_DUMP: if (w_xfer && r_dump_last) w_state_nxt = S_IDLE;
            default:                           w_state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_busy = (r_state == S_DUMP);
    end

    // Memory array: contents survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[w_bank][caddr_wr] <= cdata_wr;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cdata_rd    <= '0;
            r_dump_valid  <= 1'b0;
            r_dump_addr   <= '0;
            r_dump_data   <= '0;
            r_dump_last   <= 1'b0;
            r_dump_bank   <= '0;
            r_err_sel     <= 1'b0;
            r_err_rd_busy <= 1'b0;
            for (int unsigned i = 0; i < NUM_BANK; i++) r_wr_cnt[i] <= '0;
        end else begin
            if (w_rd_ok) begin
                if (w_wr_ok && (caddr_wr == caddr_rd)) r_cdata_rd <= cdata_wr;
                else                                   r_cdata_rd <= r_mem[w_bank][caddr_rd];
            end

            if (w_wr_ok && (r_wr_cnt[w_bank] != '1))
                r_wr_cnt[w_bank] <= r_wr_cnt[w_bank] + CNT_W'(1);

            if (w_dump_start) r_dump_bank <= dump_sel - ONE;

            if (w_load) begin
                r_dump_valid <= 1'b1;
                r_dump_addr  <= w_load_addr;
                r_dump_data  <= w_load_bypass ? cdata_wr : r_mem[r_dump_bank][w_load_addr];
                r_dump_last  <= (w_load_addr == '1);
            end else if (w_xfer && r_dump_last) begin
                r_dump_valid <= 1'b0;
                r_dump_last  <= 1'b0;
            end

            if (err_clr) begin
                r_err_sel     <= 1'b0;
                r_err_rd_busy <= 1'b0;
            end else begin
                if (w_set_sel)  r_err_sel     <= 1'b1;
                if (w_set_busy) r_err_rd_busy <= 1'b1;
            end
        end
    end

    always_comb begin
        stat_wr_cnt = '0;
        if (w_ssel_ok) stat_wr_cnt = r_wr_cnt[stat_sel - ONE];
    end

    assign cdata_rd    = r_cdata_rd;
    assign dump_valid  = r_dump_valid;
    assign dump_addr   = r_dump_addr;
    assign dump_data   = r_dump_data;
    assign dump_last   = r_dump_last;
    assign busy        = w_busy;
    assign err_sel     = r_err_sel;
    assign err_rd_busy = r_err_rd_busy;

endmodule

// File: tb/tb_cnn_layer_mem.sv
// Scoreboard bench for cnn_layer_mem: stimulus pushes expected read results
// and dump words into queues; a monitor pops and compares them when the DUT
// returns read data or transfers a dump word.
module tb_cnn_layer_mem;

    localparam int DATA_W   = 20;
    localparam int ADDR_W   = 12;
    localparam int NUM_BANK = 5;
    localparam int SEL_W    = 3;
    localparam int CNT_W    = 13;
    localparam int DEPTH    = 4096;

    logic              clk = 1'b0;
    logic              reset;
    logic [SEL_W-1:0]  csel;
    logic              crd;
    logic [ADDR_W-1:0] caddr_rd;
    logic [DATA_W-1:0] cdata_rd;
    logic              cwr;
    logic [ADDR_W-1:0] caddr_wr;
    logic [DATA_W-1:0] cdata_wr;
    logic              dump_req;
    logic [SEL_W-1:0]  dump_sel;
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;
    logic              dump_last;
    logic              busy;
    logic [SEL_W-1:0]  stat_sel;
    logic [CNT_W-1:0]  stat_wr_cnt;
    logic              err_sel;
    logic              err_rd_busy;
    logic              err_clr;

    cnn_layer_mem #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_BANK(NUM_BANK),
        .SEL_W(SEL_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .csel(csel), .crd(crd), .caddr_rd(caddr_rd),
        .cdata_rd(cdata_rd), .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .dump_req(dump_req), .dump_sel(dump_sel), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data),
        .dump_last(dump_last), .busy(busy), .stat_sel(stat_sel),
        .stat_wr_cnt(stat_wr_cnt), .err_sel(err_sel), .err_rd_busy(err_rd_busy),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              l;
    } dw_t;

    logic [DATA_W-1:0] rd_q[$];
    dw_t               dump_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: dump transfers and stall stability at the clock edge, read
    // data on the following falling edge.
    initial begin : monitor
        logic              rd_seen;
        logic              prev_stall;
        logic [ADDR_W-1:0] prev_a;
        logic [DATA_W-1:0] prev_d;
        dw_t               e;
        logic [DATA_W-1:0] r;
        prev_stall = 1'b0;
        prev_a     = '0;
        prev_d     = '0;
        forever begin
            @(posedge clk);
            rd_seen = (crd === 1'b1);
            if (prev_stall && dump_valid) begin
                chk("dump_stall_addr", 32'(dump_addr), 32'(prev_a));
                chk("dump_stall_data", 32'(dump_data), 32'(prev_d));
            end
            if (dump_valid && dump_ready) begin
                if (dump_q.size() == 0) begin
                    chk("dump_unexpected", 32'(dump_addr), 32'hFFFF_FFFF);
                end else begin
                    e = dump_q.pop_front();
                    chk("dump_addr", 32'(dump_addr), 32'(e.a));
                    chk("dump_data", 32'(dump_data), 32'(e.d));
                    chk("dump_last", 32'(dump_last), 32'(e.l));
                end
            end
            prev_stall = dump_valid && !dump_ready;
            prev_a     = dump_addr;
            prev_d     = dump_data;
            @(negedge clk);
            if (rd_seen) begin
                if (rd_q.size() == 0) begin
                    chk("rd_unexpected", 32'(cdata_rd), 32'hFFFF_FFFF);
                end else begin
                    r = rd_q.pop_front();
                    chk("rd_data", 32'(cdata_rd), 32'(r));
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        int c;
        logic [3:0] pat;
        dw_t w;
        pat = 4'b1001;

        reset = 1'b0; csel = '0; crd = 1'b0; caddr_rd = '0; cwr = 1'b0;
        caddr_wr = '0; cdata_wr = '0; dump_req = 1'b0; dump_sel = '0;
        dump_ready = 1'b0; stat_sel = 3'd1; err_clr = 1'b0;
        repeat (3) tick;
        chk("rst_cdata_rd",   32'(cdata_rd), 0);
        chk("rst_dump_valid", 32'(dump_valid), 0);
        chk("rst_dump_addr",  32'(dump_addr), 0);
        chk("rst_dump_data",  32'(dump_data), 0);
        chk("rst_dump_last",  32'(dump_last), 0);
        chk("rst_busy",       32'(busy), 0);
        chk("rst_err_sel",    32'(err_sel), 0);
        chk("rst_err_rd_busy",32'(err_rd_busy), 0);
        chk("rst_stat_cnt",   32'(stat_wr_cnt), 0);
        reset = 1'b1;
        tick;

        // Write then read back one cycle later
        csel = 3'd1; cwr = 1'b1; caddr_wr = 12'h7FF; cdata_wr = 20'h12345;
        tick;
        cwr = 1'b0; crd = 1'b1; caddr_rd = 12'h7FF; rd_q.push_back(20'h12345);
        tick;
        crd = 1'b0; stat_sel = 3'd1;
        #1 chk("stat_cnt_b1", 32'(stat_wr_cnt), 1);

        // Same-cycle write/read bypass, then a plain re-read
        csel = 3'd3; cwr = 1'b1; caddr_wr = 12'd5; cdata_wr = 20'hABCDE;
        crd = 1'b1; caddr_rd = 12'd5; rd_q.push_back(20'hABCDE);
        tick;
        cwr = 1'b0; rd_q.push_back(20'hABCDE);
        tick;
        crd = 1'b0;

        // Invalid csel: data holds, err_sel sticky, err_clr clears and wins
        csel = 3'd0; crd = 1'b1; rd_q.push_back(20'hABCDE);
        tick;
        chk("err_sel_csel0", 32'(err_sel), 1);
        csel = 3'd6; rd_q.push_back(20'hABCDE);
        tick;
        crd = 1'b0;
        chk("err_sel_csel6", 32'(err_sel), 1);
        chk("err_rd_busy_idle", 32'(err_rd_busy), 0);
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        chk("err_sel_clr", 32'(err_sel), 0);
        err_clr = 1'b1; csel = 3'd0; crd = 1'b1; rd_q.push_back(20'hABCDE);
        tick;
        err_clr = 1'b0; crd = 1'b0;
        chk("err_clr_priority", 32'(err_sel), 0);
        dump_req = 1'b1; dump_sel = 3'd0;
        tick;
        dump_req = 1'b0;
        chk("err_sel_dump_sel0", 32'(err_sel), 1);
        chk("busy_bad_dump_sel", 32'(busy), 0);
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;

        // Fill bank 2 twice with data = addr; counter saturates at 8191
        csel = 3'd2;
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < DEPTH; a++) begin
                cwr = 1'b1; caddr_wr = ADDR_W'(a); cdata_wr = DATA_W'(a);
                tick;
            end
        end
        cwr = 1'b0;
        stat_sel = 3'd2;
        #1 chk("stat_cnt_b2_sat", 32'(stat_wr_cnt), 8191);
        stat_sel = 3'd1;
        #1 chk("stat_cnt_b1_keep", 32'(stat_wr_cnt), 1);
        stat_sel = 3'd0;
        #1 chk("stat_cnt_invalid", 32'(stat_wr_cnt), 0);

        // Full-speed dump of bank 2
        for (int a = 0; a < DEPTH; a++) begin
            w.a = ADDR_W'(a); w.d = DATA_W'(a); w.l = (a == DEPTH - 1);
            dump_q.push_back(w);
        end
        dump_ready = 1'b1; dump_req = 1'b1; dump_sel = 3'd2;
        tick;
        dump_req = 1'b0;
        chk("dump_busy_T", 32'(busy), 1);
        chk("dump_valid_T", 32'(dump_valid), 0);
        tick;
        chk("dump_valid_T1", 32'(dump_valid), 1);
        chk("dump_addr_T1", 32'(dump_addr), 0);
        n = 1;
        while (busy && n < 6000) begin
            tick;
            n++;
        end
        chk("dump_end_cycle", 32'(n), 4097);
        chk("dump_valid_end", 32'(dump_valid), 0);
        chk("dump_q_empty_1", 32'(dump_q.size()), 0);

        // Fill bank 1 with 3*addr, then dump with stalls and writes
        csel = 3'd1;
        for (int a = 0; a < DEPTH; a++) begin
            cwr = 1'b1; caddr_wr = ADDR_W'(a); cdata_wr = DATA_W'(a * 3);
            tick;
        end
        cwr = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            w.a = ADDR_W'(a);
            w.d = (a == 12'hF00) ? 20'h5A5A5 : DATA_W'(a * 3);
            w.l = (a == DEPTH - 1);
            dump_q.push_back(w);
        end
        dump_ready = 1'b0; dump_req = 1'b1; dump_sel = 3'd1;
        tick;
        dump_req = 1'b0;
        c = 0;
        while (busy && c < 20000) begin
            dump_ready = pat[c % 4];
            cwr = 1'b0; crd = 1'b0;
            if (c == 3)  begin cwr = 1'b1; caddr_wr = 12'hF00; cdata_wr = 20'h5A5A5; end
            if (c == 20) begin cwr = 1'b1; caddr_wr = 12'h000; cdata_wr = 20'h77777; end
            if (c == 30) begin crd = 1'b1; caddr_rd = 12'h000; rd_q.push_back(20'hABCDE); end
            tick;
            c++;
        end
        cwr = 1'b0; crd = 1'b0; dump_ready = 1'b0;
        chk("dump2_done", 32'(busy), 0);
        chk("dump_q_empty_2", 32'(dump_q.size()), 0);
        chk("err_rd_busy_set", 32'(err_rd_busy), 1);
        crd = 1'b1; caddr_rd = 12'h000; rd_q.push_back(20'h77777);
        tick;
        caddr_rd = 12'hF00; rd_q.push_back(20'h5A5A5);
        tick;
        crd = 1'b0;

        // Reset in the middle of a dump of bank 2
        for (int a = 0; a < 100; a++) begin
            w.a = ADDR_W'(a); w.d = DATA_W'(a); w.l = 1'b0;
            dump_q.push_back(w);
        end
        dump_ready = 1'b1; dump_req = 1'b1; dump_sel = 3'd2;
        tick;
        dump_req = 1'b0;
        tick;
        repeat (100) tick;
        reset = 1'b0; dump_ready = 1'b0; stat_sel = 3'd2;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_valid", 32'(dump_valid), 0);
        chk("mid_rst_addr", 32'(dump_addr), 0);
        chk("mid_rst_cnt", 32'(stat_wr_cnt), 0);
        chk("mid_rst_cdata", 32'(cdata_rd), 0);
        chk("dump_q_empty_3", 32'(dump_q.size()), 0);
        tick;
        reset = 1'b1;
        tick;
        for (int a = 0; a < DEPTH; a++) begin
            w.a = ADDR_W'(a); w.d = DATA_W'(a); w.l = (a == DEPTH - 1);
            dump_q.push_back(w);
        end
        dump_ready = 1'b1; dump_req = 1'b1; dump_sel = 3'd2;
        tick;
        dump_req = 1'b0;
        tick;
        chk("redump_addr0", 32'(dump_addr), 0);
        n = 0;
        while (busy && n < 6000) begin
            tick;
            n++;
        end
        chk("redump_done", 32'(busy), 0);
        repeat (3) tick;
        chk("dump_q_empty_4", 32'(dump_q.size()), 0);
        chk("rd_q_empty", 32'(rd_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cnn_layer_mem.md
# cnn_layer_mem

Parametrised, synthesizable multi-bank layer memory for the CNN accelerator. It generalises the per-layer result memories that the CONV bench models, with a configurable bank count, depth and word width. It adds write-first bypass, per-bank write counters, sticky protocol-error flags and a valid/ready dump port that streams one bank out for on-line checking. It sits between CONV's `crd`/`cwr`/`csel` port and either the testfixture or an on-chip result buffer.

## Interface
- DATA_W, 20, word width of every bank
- ADDR_W, 12, address width; each bank holds 2^ADDR_W words
- NUM_BANK, 5, number of banks; bank k is selected by csel = k+1
- SEL_W, 3, csel width; must satisfy 2^SEL_W > NUM_BANK
- CNT_W, ADDR_W+1, write-counter width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- csel  in  SEL_W  bank select shared by read and write
- crd  in  1  read strobe
- caddr_rd  in  ADDR_W  read address
- cdata_rd  out  DATA_W  registered read data
- cwr  in  1  write strobe
- caddr_wr  in  ADDR_W  write address
- cdata_wr  in  DATA_W  write data
- dump_req  in  1  start a dump, sampled only in IDLE
- dump_sel  in  SEL_W  bank to dump, sampled with dump_req
- dump_valid  out  1  dump word valid
- dump_ready  in  1  consumer accepts word
- dump_addr  out  ADDR_W  address of the current dump word
- dump_data  out  DATA_W  current dump word
- dump_last  out  1  current word is address 2^ADDR_W-1
- busy  out  1  dump in progress
- stat_sel  in  SEL_W  bank whose write count is shown
- stat_wr_cnt  out  CNT_W  write count of bank stat_sel (combinational mux)
- err_sel  out  1  sticky: crd or cwr with csel=0 or csel>NUM_BANK, or dump_req with an invalid dump_sel
- err_rd_busy  out  1  sticky: crd asserted while busy
- err_clr  in  1  synchronous clear of both sticky flags

## Operation
- Memory contents are not reset. Reset clears all registers and counters only.
- Write: on cwr with a valid csel, mem[csel-1][caddr_wr] <= cdata_wr, and that bank's counter increments, saturating at 2^CNT_W-1. cwr with an invalid csel writes nothing and sets err_sel.
- Read: on crd with a valid csel and busy=0, cdata_rd <= mem[csel-1][caddr_rd].
  - Write-first bypass: if cwr is also asserted and caddr_wr==caddr_rd in the same cycle, cdata_rd <= cdata_wr.
  - Invalid csel: cdata_rd holds its value and err_sel is set.
- crd while busy: ignored, cdata_rd holds, err_rd_busy is set. cwr is still accepted during a dump.
- FSM IDLE -> DUMP -> IDLE.
  - IDLE: dump_req with a valid dump_sel latches the bank and enters DUMP. With an invalid dump_sel, the FSM stays in IDLE and sets err_sel.
  - DUMP: streams addresses 0 .. 2^ADDR_W-1 in order. A word is transferred on dump_valid & dump_ready. dump_addr, dump_data and dump_last are held stable while dump_valid & !dump_ready.
  - After the transfer with dump_last=1, the FSM returns to IDLE. busy=0 and dump_valid=0 in the following cycle.
- Write during a dump to the dumped bank:
  - address not yet presented: the new value is dumped.
  - address already presented: no effect on the stream.
  - address currently presented and stalled: dump_data keeps its old value.
- err_clr has priority over a same-cycle set.

## Timing
- Reset values: cdata_rd=0, dump_valid=0, dump_addr=0, dump_data=0, dump_last=0, busy=0, err_sel=0, err_rd_busy=0, all counters=0, FSM=IDLE.
- Read latency 1: crd at edge T gives cdata_rd valid after edge T, held until the next accepted read.
- Write visible to a crd in the same cycle (bypass) and to any later read.
- Dump:
  - dump_req accepted at edge T: busy=1 after T.
  - dump_valid=1 with address 0 after edge T+1.
  - With dump_ready held high, one word per cycle; the full bank takes 2^ADDR_W cycles after the first valid.
- Reset asserted mid-dump: immediately IDLE, busy=0, dump_valid=0, counters cleared, memory retained.

## Test plan
- Write 0x12345 to bank 1 addr 0x7FF, then crd same address next cycle -> cdata_rd=0x12345 one cycle later. stat_sel=1 gives stat_wr_cnt=1.
- Same-cycle cwr(0xABCDE) and crd, csel=3, both addr 5 -> cdata_rd=0xABCDE. A later read of addr 5 returns 0xABCDE.
- crd with csel=0 and csel=6 -> cdata_rd unchanged, err_sel=1. Pulse err_clr -> err_sel=0 next cycle.
- Fill bank 2 with data=addr, dump_req with dump_sel=2, dump_ready=1 -> 4096 words 0..0xFFF in order. dump_last only on 0xFFF; busy falls one cycle after the last transfer.
- Dump with dump_ready toggling 1,0,0,1 -> dump_addr and dump_data stable during stalls, no word lost or duplicated. crd during the dump -> err_rd_busy=1.
- Reset asserted at dump word 100 -> busy=0 and dump_valid=0 at once. A new dump afterwards restarts at address 0 with contents intact.
